prng_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one `prng` core among `NREQ` hardware requesters. Each accepted request returns one 32-bit random word with a one-cycle `ack`. The block owns the core's `rst`, `seed` and `next` pins and serialises reseeding against draws. It sits between the `prng` instance and the fabric peripherals that need random numbers. A seed source, such as an MCS IO register, drives `seed_wr`/`seed_in`.

---
 rtl/prng_arb.sv | 138 +++++++++++++
 tb/tb_prng_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/prng_arb.sv
// Round-robin arbiter sharing one prng core among NREQ requesters; also sequences core reseeding.
// Optional automatic reseed every RESEED_INTERVAL grants is enabled by defining PRNG_ARB_RESEED_EN.
module prng_arb #(
  parameter int NREQ            = 4,
  parameter int RESEED_INTERVAL = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic [31:0]     data,
  input  logic            seed_wr,
  input  logic [31:0]     seed_in,
  output logic            busy,
  output logic            prng_rst,
  output logic [31:0]     prng_seed,
  output logic            prng_next,
  input  logic [31:0]     prng_num
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);
  localparam logic [LW:0]   NREQ_W   = (LW+1)'(NREQ);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ADV} state_t;

  state_t          r_state, w_state_next;
  logic [NREQ-1:0] r_ack;
  logic [31:0]     r_data;
  logic [31:0]     r_seed;
  logic            r_pend;
  logic [LW-1:0]   r_last;

  logic [LW:0]       w_base;
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [LW-1:0]     w_off;
  logic [LW:0]       w_sum;
  logic [LW-1:0]     w_win;
  logic              w_any;
  logic [NREQ-1:0]   w_onehot;
  logic              w_grant;

  // Rotate requests so bit 0 is the index right after the last winner, then take the lowest set bit.
  always_comb begin
    w_base = {1'b0, r_last} + 1'b1;
    w_dbl  = {req, req};
    w_rot  = w_dbl[w_base +: NREQ];
    w_any  = |w_rot;
    w_off  = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = LW'(j);
    end
    w_sum = w_base + {1'b0, w_off};
    w_win = (w_sum >= NREQ_W) ? LW'(w_sum - NREQ_W) : w_sum[LW-1:0];
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign w_onehot[gi] = (w_win == LW'(gi));
  end

  assign w_grant = (r_state == S_IDLE) && !r_pend && w_any;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_INIT: w_state_next = S_IDLE;
      S_IDLE: begin
        if (r_pend)     w_state_next = S_INIT;
        else if (w_any) w_state_next = S_ADV;
      end
      S_ADV:  w_state_next = S_IDLE;
      default: w_state_next = S_INIT;
    endcase
  end

`ifdef PRNG_ARB_RESEED_EN
  localparam int CW = $clog2(RESEED_INTERVAL) + 1;
  localparam logic [CW-1:0] CNT_WRAP = CW'(RESEED_INTERVAL - 1);
  logic [CW-1:0] r_cnt;
`else
  // Keeps the interval parameter referenced when the auto-reseed counter is not built.
  logic [31:0] w_unused_interval;
  assign w_unused_interval = RESEED_INTERVAL;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack  <= '0;
      r_data <= '0;
      r_seed <= '0;
      r_pend <= 1'b0;
      r_last <= LAST_RST;
`ifdef PRNG_ARB_RESEED_EN
      r_cnt  <= '0;
`endif
    end else begin
      r_ack <= '0;
      if (w_grant) begin
        r_ack  <= w_onehot;
        r_data <= prng_num;
        r_last <= w_win;
      end
      if ((r_state == S_IDLE) && r_pend) r_pend <= 1'b0;
`ifdef PRNG_ARB_RESEED_EN
      if (r_state == S_INIT) begin
        r_cnt <= '0;
      end else if (w_grant) begin
        if (r_cnt == CNT_WRAP) begin
          r_cnt  <= '0;
          r_seed <= r_seed ^ prng_num;
          r_pend <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
`endif
      // An external seed write takes priority over both pend-clear and the automatic seed.
      if (seed_wr) begin
        r_seed <= seed_in;
        r_pend <= 1'b1;
      end
    end
  end

  assign ack       = r_ack;
  assign data      = r_data;
  assign prng_seed = r_seed;
  assign prng_rst  = (r_state == S_INIT);
  assign prng_next = (r_state == S_ADV);
  assign busy      = (r_state != S_IDLE) | r_pend;

endmodule

// File: tb/tb_prng_arb.sv
// Directed bench for prng_arb with a small LCG stand-in for the prng core.
// Define PRNG_ARB_RESEED_EN to exercise the automatic reseed path instead of the plain draw sequences.
module tb_prng_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic [31:0] data;
  logic        seed_wr;
  logic [31:0] seed_in;
  logic        busy;
  logic        prng_rst;
  logic [31:0] prng_seed;
  logic        prng_next;
  logic [31:0] prng_num;
  logic [31:0] core_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prng_arb #(.NREQ(4), .RESEED_INTERVAL(4)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .data(data),
    .seed_wr(seed_wr), .seed_in(seed_in), .busy(busy),
    .prng_rst(prng_rst), .prng_seed(prng_seed), .prng_next(prng_next),
    .prng_num(prng_num)
  );

  function automatic logic [31:0] lcg(input logic [31:0] x);
    return x * 32'd1664525 + 32'd1013904223;
  endfunction

  // Word k (k>=1) produced by the core after being loaded with seed.
  function automatic logic [31:0] word(input logic [31:0] seed, input int k);
    logic [31:0] s;
    s = seed;
    for (int i = 0; i < k; i++) s = lcg(s);
    return s;
  endfunction

  // Core model: rst loads the first word of the seed, next steps it, num is the current state.
  always @(posedge clk) begin
    if (prng_rst)       core_s <= lcg(prng_seed);
    else if (prng_next) core_s <= lcg(core_s);
  end
  assign prng_num = core_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_seq();
    rst = 1'b1; req = '0; seed_wr = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    logic [31:0] prev;
    logic [3:0]  exp_ack;
    int          n_ack;
    int          n_init;

    rst = 1'b1; req = '0; seed_wr = 1'b0; seed_in = '0;

    // Reset and idle
    cyc();
    chk("rst_prng_rst", {31'd0, prng_rst}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_next", {31'd0, prng_next}, 32'd0);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_data", data, 32'd0);
    cyc();
    rst = 1'b0;
    chk("post_rst_init", {31'd0, prng_rst}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("idle_prng_rst", {31'd0, prng_rst}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_ack", {28'd0, ack}, 32'd0);
      chk("idle_data", data, 32'd0);
    end

`ifndef PRNG_ARB_RESEED_EN
    // Single requester: one word every second cycle
    req = 4'b0010;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i % 2 == 1) begin
        chk("r1_ack", {28'd0, ack}, 32'h2);
        chk("r1_data", data, word(32'd0, (i + 1) / 2));
        chk("r1_next", {31'd0, prng_next}, 32'd1);
      end else begin
        chk("r1_ack_gap", {28'd0, ack}, 32'd0);
        chk("r1_data_hold", data, word(32'd0, i / 2));
      end
      if (i == 9) req = '0;
    end

    // All requesters: round-robin order from index 0
    reset_seq();
    req  = 4'b1111;
    prev = '0;
    for (int g = 0; g < 6; g++) begin
      cyc();
      exp_ack = 4'b0001 << (g % 4);
      chk("rr_ack", {28'd0, ack}, {28'd0, exp_ack});
      chk("rr_data", data, word(32'd0, g + 1));
      chk("rr_next", {31'd0, prng_next}, 32'd1);
      checks++;
      assert (data !== prev) else begin
        errors++;
        $error("FAIL rr_unique: observed %h expected a value other than %h", data, prev);
      end
      prev = data;
      if (g == 5) req = '0;
      cyc();
      chk("rr_ack_gap", {28'd0, ack}, 32'd0);
    end

    // Seed write together with a grant: grant first, then INIT
    req = 4'b0100; seed_in = 32'hDEADBEEF; seed_wr = 1'b1;
    cyc();
    seed_wr = 1'b0;
    chk("sw_ack", {28'd0, ack}, 32'h4);
    chk("sw_data", data, word(32'd0, 7));
    chk("sw_busy_adv", {31'd0, busy}, 32'd1);
    cyc();
    chk("sw_busy_pend", {31'd0, busy}, 32'd1);
    chk("sw_no_ack", {28'd0, ack}, 32'd0);
    cyc();
    chk("sw_init", {31'd0, prng_rst}, 32'd1);
    chk("sw_seed", prng_seed, 32'hDEADBEEF);
    cyc();
    chk("sw_idle_busy", {31'd0, busy}, 32'd0);
    cyc();
    req = '0;
    chk("sw_ack2", {28'd0, ack}, 32'h4);
    chk("sw_word1", data, word(32'hDEADBEEF, 1));
    cyc();
    seed_wr = 1'b1;
    cyc();
    seed_wr = 1'b0;
    chk("rs_busy", {31'd0, busy}, 32'd1);
    cyc();
    chk("rs_init", {31'd0, prng_rst}, 32'd1);
    cyc();
    chk("rs_idle", {31'd0, prng_rst}, 32'd0);
    req = 4'b0100;
    cyc();
    chk("rs_word1", data, word(32'hDEADBEEF, 1));
    cyc();
    cyc();
    req = '0;
    chk("rs_word2", data, word(32'hDEADBEEF, 2));
    cyc();
`endif

    // Reset during ADV drops ack and restarts the round-robin pointer
    reset_seq();
    req = 4'b1000;
    cyc();
    chk("ra_ack3", {28'd0, ack}, 32'h8);
    rst = 1'b1; req = 4'b1001;
    cyc();
    rst = 1'b0;
    chk("ra_ack_drop", {28'd0, ack}, 32'd0);
    chk("ra_init", {31'd0, prng_rst}, 32'd1);
    chk("ra_seed", prng_seed, 32'd0);
    cyc();
    chk("ra_idle_busy", {31'd0, busy}, 32'd0);
    cyc();
    req = '0;
    chk("ra_first", {28'd0, ack}, 32'h1);
    chk("ra_data", data, word(32'd0, 1));
    cyc();

`ifdef PRNG_ARB_RESEED_EN
    // Automatic reseed after the 4th grant
    reset_seq();
    req = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i % 2 == 1) chk("ar_data", data, word(32'd0, (i + 1) / 2));
      if (i == 7) req = '0;
    end
    chk("ar_busy", {31'd0, busy}, 32'd1);
    cyc();
    chk("ar_init", {31'd0, prng_rst}, 32'd1);
    chk("ar_seed", prng_seed, word(32'd0, 4));
`else
    // Without the counter, 20 grants cause no INIT
    req = 4'b0001; n_ack = 0; n_init = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (ack[0]) n_ack++;
      if (prng_rst) n_init++;
      if (i == 39) req = '0;
    end
    chk("nr_acks", n_ack, 32'd20);
    chk("nr_inits", n_init, 32'd0);
    chk("nr_data", data, word(32'd0, 21));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
